clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Programmable integer clock divider: the generalised successor to the team's fixed divide-by-2 divider. It produces a near-50% duty divided enable-clock `q` and a one-cycle `tick` strobe at each period start. The divide ratio can be changed at run time; a new ratio takes effect only at a period boundary, so `q` never glitches. It sits beside the system clock, feeding slow-rate logic (UART baud, LED scan, sample strobes) as a clock-enable source.

Parameters:
- WIDTH, 8, width of divide ratio and internal counter.
- RESET_DIV, 2, divide ratio after reset. Must satisfy 2 <= RESET_DIV <= 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when 0, divider state is frozen.
- div_in  input  WIDTH  requested divide ratio.
- div_load  input  1  1-cycle request to load div_in.
- q  output  1  divided output, registered.
- tick  output  1  1-cycle pulse on the first cycle of each q period, registered.
- div_cur  output  WIDTH  ratio currently in effect.
- pending  output  1  a loaded ratio is waiting for the next period boundary.
- load_err  output  1  1-cycle pulse: a load was rejected (div_in < 2).

Behaviour:
- Reset (async, immediate):
  - cnt = RESET_DIV-1, div_cur = RESET_DIV.
  - q = 0, tick = 0, pending = 0, div_pend = 0, load_err = 0.
- Period: div_cur clk cycles (en=1 throughout). q is high for floor(div_cur/2) cycles, then low for ceil(div_cur/2) cycles.
- Per rising edge with en=1:
  - Wrap case, when cnt == div_cur-1:
    - cnt <= 0, q <= 1, tick <= 1.
    - If pending: div_cur <= div_pend and pending <= 0. The new ratio governs the period that starts now.
  - Otherwise:
    - cnt <= cnt+1, tick <= 0.
    - q <= ((cnt+1) < (div_cur>>1)). Compare at WIDTH bits; no overflow, since cnt+1 <= div_cur-1.
- First enabled edge after reset wraps immediately: q=1 and tick=1 one cycle after rst deasserts (with en=1). There is no truncated first period.
- en=0: cnt, q, div_cur are held; tick <= 0. Resuming continues mid-period exactly where it left off.
- Load handling (independent of en):
  - Accepted load: div_load=1 and div_in >= 2 gives div_pend <= div_in and pending <= 1.
  - Rejected load: div_load=1 and div_in < 2 gives load_err <= 1 for one cycle. The load is ignored and pending/div_pend are unchanged.
  - Load while pending=1: overwrites div_pend. Last accepted value wins.
  - Load on the same edge as a wrap: the wrap uses the pre-edge pending/div_pend. The new value becomes pending and applies at the following wrap. The wrap clears pending only if no load is accepted on that edge.
  - Load of a value equal to div_cur: accepted normally; no visible change.
- Ratio range: 2 .. 2^WIDTH-1. Ratio 2 gives q toggling every cycle (1 high, 1 low).
- Reset mid-period or with a pending load:
  - Pending value is discarded.
  - Restart per the reset rules above, with div_cur = RESET_DIV.

Test Plan:
1. Reset/default: WIDTH=8, RESET_DIV=2, 10 ns clk. rst=1 for 10 ns, en=1 → q and tick rise on the first edge after release. q toggles with a 20 ns period; tick is high every other cycle; div_cur=2.
2. Odd ratio: load div_in=5 → after the next wrap, q is 2 cycles high and 3 low, repeating. tick occurs every 5 cycles. pending is 1 from the load until that wrap.
3. Boundary-safe change: with div_cur=8, load 3 when cnt=2 → the current period completes all 8 cycles (q 4 high / 4 low), then switches to 3-cycle periods. No runt pulse on q.
4. Rejected/overwritten loads:
   - div_in=0 → load_err pulses 1 cycle; div_cur unchanged.
   - div_in=1 → same result.
   - Loads of 6 then 4 before a wrap → div_cur becomes 4; 6 never appears.
5. Enable freeze: div_cur=6, en=0 for 7 cycles at cnt=1 → q and cnt held, tick=0 throughout. On resume, the remaining 4 cycles of the period complete before the next tick.
6. Reset mid-operation: div_cur=10, pending=1 (div_pend=7), assert rst asynchronously between edges → q, tick and pending go to 0 immediately. After release, div_cur=2 and the first edge gives q=1, tick=1.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives ratio requests and enable; the slave reports divided output and status.
interface clk_div_prog_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             q;
    logic             tick;
    logic [WIDTH-1:0] div_cur;
    logic             pending;
    logic             load_err;

    modport master (
        output en, div_in, div_load,
        input  q, tick, div_cur, pending, load_err
    );

    modport slave (
        input  en, div_in, div_load,
        output q, tick, div_cur, pending, load_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a near-50% duty enable-clock q and a period-start tick.
// Ratio changes are staged in div_pend and only take effect at a period boundary.
module clk_div_prog #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    clk_div_prog_if.slave     bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pending_q, pending_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] cnt_inc;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;

    assign cnt_inc  = cnt_q + WIDTH'(1);
    assign wrap     = (cnt_q == div_cur_q - WIDTH'(1));
    assign load_ok  = bus.div_load && (bus.div_in >= WIDTH'(2));
    assign load_bad = bus.div_load && (bus.div_in < WIDTH'(2));

    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pending_d  = pending_q;
        q_d        = q_q;
        tick_d     = 1'b0;
        load_err_d = load_bad;

        if (bus.en) begin
            if (wrap) begin
                cnt_d  = '0;
                q_d    = 1'b1;
                tick_d = 1'b1;
                if (pending_q) begin
                    div_cur_d = div_pend_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_inc;
                q_d   = (cnt_inc < (div_cur_q >> 1));
            end
        end

        // A load accepted on a wrap edge must survive the wrap clearing pending.
        if (load_ok) begin
            div_pend_d = bus.div_in;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= WIDTH'(RESET_DIV - 1);
            div_cur_q  <= WIDTH'(RESET_DIV);
            div_pend_q <= '0;
            pending_q  <= 1'b0;
            q_q        <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pending_q  <= pending_d;
            q_q        <= q_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.tick     = tick_q;
    assign bus.div_cur  = div_cur_q;
    assign bus.pending  = pending_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reset, odd ratios, boundary-safe changes, rejected
// and overwritten loads, enable freeze and asynchronous reset mid-operation.
module tb_clk_div_prog;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    clk_div_prog_if #(.WIDTH(8)) bus ();

    clk_div_prog #(
        .WIDTH    (8),
        .RESET_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full period of ratio d, starting with the wrap edge; optionally loads
    // ld_val on the edge at index ld_at (-1 for none).
    task automatic run_period(input int d, input int ld_at, input int ld_val, input string tag);
        for (int i = 0; i < d; i++) begin
            if (i == ld_at) begin
                bus.div_in   = 8'(ld_val);
                bus.div_load = 1'b1;
            end
            step();
            bus.div_load = 1'b0;
            chk({tag, ".q"}, 32'(bus.q), 32'(i < d / 2));
            chk({tag, ".tick"}, 32'(bus.tick), 32'(i == 0));
            chk({tag, ".div_cur"}, 32'(bus.div_cur), 32'(d));
        end
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;

        // 1. Reset and default ratio 2
        #1 rst = 1'b1;
        #2;
        chk("rst.q", 32'(bus.q), 0);
        chk("rst.tick", 32'(bus.tick), 0);
        chk("rst.pending", 32'(bus.pending), 0);
        chk("rst.load_err", 32'(bus.load_err), 0);
        chk("rst.div_cur", 32'(bus.div_cur), 2);
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b1;
        run_period(2, -1, 0, "div2a");
        run_period(2, -1, 0, "div2b");

        // 2. Odd ratio 5, loaded on a wrap edge so it applies one period later
        bus.div_in   = 8'd5;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        chk("ld5.tick", 32'(bus.tick), 1);
        chk("ld5.pending", 32'(bus.pending), 1);
        chk("ld5.div_cur", 32'(bus.div_cur), 2);
        step();
        chk("ld5.q_low", 32'(bus.q), 0);
        chk("ld5.pending2", 32'(bus.pending), 1);
        run_period(5, -1, 0, "div5a");
        chk("div5.pending", 32'(bus.pending), 0);
        run_period(5, -1, 0, "div5b");

        // 4. Rejected loads, then overwritten load 6 -> 4
        bus.div_in   = 8'd0;
        bus.div_load = 1'b1;
        step();
        chk("rej0.load_err", 32'(bus.load_err), 1);
        chk("rej0.pending", 32'(bus.pending), 0);
        chk("rej0.tick", 32'(bus.tick), 1);
        bus.div_in = 8'd1;
        step();
        chk("rej1.load_err", 32'(bus.load_err), 1);
        chk("rej1.pending", 32'(bus.pending), 0);
        bus.div_load = 1'b0;
        step();
        chk("rej.err_clear", 32'(bus.load_err), 0);
        chk("rej.div_cur", 32'(bus.div_cur), 5);
        bus.div_in   = 8'd6;
        bus.div_load = 1'b1;
        step();
        chk("ld6.pending", 32'(bus.pending), 1);
        bus.div_in = 8'd4;
        step();
        bus.div_load = 1'b0;
        chk("ld4.pending", 32'(bus.pending), 1);
        chk("ld4.load_err", 32'(bus.load_err), 0);
        run_period(4, -1, 0, "div4a");
        run_period(4, -1, 0, "div4b");

        // 3. Ratio 8, then load 3 at cnt=2: the 8-cycle period completes untruncated
        run_period(4, 0, 8, "div4_ld8");
        run_period(8, 2, 3, "div8_ld3");
        chk("div8.pending", 32'(bus.pending), 1);
        run_period(3, -1, 0, "div3a");
        run_period(3, 1, 6, "div3_ld6");

        // 5. Enable freeze at cnt=1 with ratio 6
        step();
        chk("frz.wrap_tick", 32'(bus.tick), 1);
        chk("frz.div_cur", 32'(bus.div_cur), 6);
        step();
        chk("frz.q_cnt1", 32'(bus.q), 1);
        bus.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("frz.q_hold", 32'(bus.q), 1);
            chk("frz.tick_hold", 32'(bus.tick), 0);
        end
        bus.en = 1'b1;
        for (int i = 2; i < 6; i++) begin
            step();
            chk("frz.resume_q", 32'(bus.q), 32'(i < 3));
            chk("frz.resume_tick", 32'(bus.tick), 0);
        end
        step();
        chk("frz.next_tick", 32'(bus.tick), 1);

        // 6. Ratio 10 with 7 pending, then asynchronous reset between edges
        bus.div_in   = 8'd10;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("r10.div_cur", 32'(bus.div_cur), 10);
        chk("r10.tick", 32'(bus.tick), 1);
        bus.div_in   = 8'd7;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        chk("r10.pending", 32'(bus.pending), 1);
        chk("r10.q_high", 32'(bus.q), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.q", 32'(bus.q), 0);
        chk("arst.tick", 32'(bus.tick), 0);
        chk("arst.pending", 32'(bus.pending), 0);
        chk("arst.div_cur", 32'(bus.div_cur), 2);
        #1 rst = 1'b0;
        run_period(2, -1, 0, "post_rst_a");
        run_period(2, -1, 0, "post_rst_b");
        chk("post_rst.pending", 32'(bus.pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
